// File: rtl/cond_check_stage.sv
// Condition-check stage: evaluates ARM32 cond against N/Z/C/V and stalls behind in-flight flag writers.
// Optional CCS_FLAG_BYPASS_EN lets a conditional capture in the same cycle as the last flag_wb.
module cond_check_stage #(
  parameter int unsigned PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        in_sets_flags,
  input  logic [31:0] status_in,
  input  logic        flag_wb,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_exec,
  output logic        out_sets_flags,
  output logic        err_underflow
);

  localparam logic [PEND_W-1:0] PendMax = '1;
  localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

  logic [PEND_W-1:0] pend_q, pend_d;
  logic [3:0]        cond;
  logic              flag_n, flag_z, flag_c, flag_v;
  logic              cond_pass;
  logic              pend_busy;
  logic              out_setter;
  logic              inflight;
  logic              hazard;
  logic [PEND_W:0]   occupancy;
  logic              full;
  logic              full_block;
  logic              capture;
  logic              out_fire;
  logic              pend_inc;
  logic              underflow;
  logic              unused_status;

  assign cond   = in_instr[31:28];
  assign flag_n = status_in[31];
  assign flag_z = status_in[30];
  assign flag_c = status_in[29];
  assign flag_v = status_in[28];
  assign unused_status = ^status_in[27:0];

  always_comb begin
    cond_pass = 1'b0;
    unique case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = ~flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = ~flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = ~flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = ~flag_v;
      4'h8: cond_pass = flag_c & ~flag_z;
      4'h9: cond_pass = ~flag_c | flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = ~flag_z & (flag_n == flag_v);
      4'hD: cond_pass = flag_z | (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      4'hF: cond_pass = 1'b0;
    endcase
  end

`ifdef CCS_FLAG_BYPASS_EN
  // The write retiring this cycle already shows on status_in, so it no longer counts.
  assign pend_busy = (pend_q > {{(PEND_W-1){1'b0}}, flag_wb});
`else
  assign pend_busy = (pend_q != '0);
`endif

  assign out_setter = out_valid & out_sets_flags;
  assign inflight   = pend_busy | out_setter;
  assign hazard     = in_valid & (cond != 4'hE) & (cond != 4'hF) & inflight;

  // The setter waiting in the output register is counted so its handshake cannot wrap pend.
  assign occupancy  = {1'b0, pend_q} + {{PEND_W{1'b0}}, out_setter};
  assign full       = (occupancy >= {1'b0, PendMax}) & ~flag_wb;
  assign full_block = full & in_sets_flags;

  assign in_ready = (~out_valid | out_ready) & ~hazard & ~full_block & ~flush;
  assign capture  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~flush;
  assign pend_inc = out_fire & out_sets_flags;
  assign underflow = flag_wb & (pend_q == '0);

  always_comb begin
    pend_d = pend_q;
    if (pend_inc && !flag_wb) begin
      pend_d = pend_q + PendOne;
    end else if (!pend_inc && flag_wb && (pend_q != '0)) begin
      pend_d = pend_q - PendOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q        <= '0;
      err_underflow <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (underflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_instr      <= '0;
      out_exec       <= 1'b0;
      out_sets_flags <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid      <= 1'b1;
      out_instr      <= in_instr;
      out_exec       <= cond_pass;
      out_sets_flags <= in_sets_flags & cond_pass;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cond_check_stage.sv
// Self-checking bench for cond_check_stage: directed scenarios plus randomized traffic vs a model.
module tb_cond_check_stage;

  localparam int PW      = 2;
  localparam int PendMax = (1 << PW) - 1;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        in_sets_flags;
  logic [31:0] status_in;
  logic        flag_wb;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_exec;
  logic        out_sets_flags;
  logic        err_underflow;

  int n_vec;
  int n_err;

  // Reference state: count of outstanding writers and the contents of the output slot.
  int          m_pend;
  bit          m_ov;
  bit          m_exec;
  bit          m_sf;
  bit          m_err;
  logic [31:0] m_instr;

  cond_check_stage #(.PEND_W(PW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_sets_flags  (in_sets_flags),
    .status_in      (status_in),
    .flag_wb        (flag_wb),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_exec       (out_exec),
    .out_sets_flags (out_sets_flags),
    .err_underflow  (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  function automatic bit cond_ok(input logic [3:0] c, input logic [31:0] st);
    bit n, z, cy, v;
    n = st[31]; z = st[30]; cy = st[29]; v = st[28];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_ready();
    int  waiting;
    int  held;
    bit  inflight, hazard, full;
    held = (m_ov && m_sf) ? 1 : 0;
`ifdef CCS_FLAG_BYPASS_EN
    waiting = m_pend - (flag_wb ? 1 : 0);
`else
    waiting = m_pend;
`endif
    inflight = (waiting > 0) || (held != 0);
    hazard   = in_valid && (in_instr[31:28] < 4'hE) && inflight;
    full     = ((m_pend + held) >= PendMax) && !flag_wb;
    return !(m_ov && !out_ready) && !hazard && !(full && in_sets_flags) && !flush;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_ov = 0; m_exec = 0; m_sf = 0; m_err = 0; m_instr = '0;
  endtask

  // Advance one clock: model consumes the inputs currently driven, then both sides step.
  task automatic cycle();
    bit          cap, fire, inc, n_ov, n_exec, n_sf, n_err_flag;
    int          n_pend;
    logic [31:0] n_instr;
    cap  = in_valid && exp_ready();
    fire = m_ov && out_ready && !flush;
    inc  = fire && m_sf;
    n_pend = m_pend;
    n_err_flag = m_err;
    if (flag_wb && m_pend == 0) n_err_flag = 1;
    if (inc && !flag_wb) n_pend = m_pend + 1;
    else if (!inc && flag_wb && m_pend > 0) n_pend = m_pend - 1;
    n_ov = m_ov; n_exec = m_exec; n_sf = m_sf; n_instr = m_instr;
    if (flush) n_ov = 0;
    else if (cap) begin
      n_ov = 1;
      n_instr = in_instr;
      n_exec = cond_ok(in_instr[31:28], status_in);
      n_sf = in_sets_flags && n_exec;
    end else if (fire) n_ov = 0;
    @(posedge clk);
    #1;
    m_pend = n_pend; m_err = n_err_flag;
    m_ov = n_ov; m_exec = n_exec; m_sf = n_sf; m_instr = n_instr;
  endtask

  task automatic drive_idle();
    in_valid = 0; in_sets_flags = 0; flag_wb = 0; flush = 0; out_ready = 1;
    in_instr = '0;
  endtask

  task automatic test_power_on();
    rst_n = 0;
    drive_idle();
    status_in = '0;
    model_reset();
    #2;
    n_vec++;
    if ({out_valid, out_exec, out_sets_flags, err_underflow, out_instr} !== '0) begin
      $display("FAIL reset_outputs: got v=%b e=%b sf=%b err=%b instr=%h, required all 0",
               out_valid, out_exec, out_sets_flags, err_underflow, out_instr);
      n_err++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      n_err++;
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cond_table();
    logic [15:0] tbl;
    logic [3:0]  c;
    tbl = 16'h66A5;
    drive_idle();
    status_in = {4'b0110, 28'($urandom)};
    for (int i = 0; i < 16; i++) begin
      c = 4'(i);
      in_valid = 1;
      in_instr = {c, 28'($urandom)};
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        $display("FAIL cond_ready[%0d]: got %b, required 1", i, in_ready);
        n_err++;
      end
      cycle();
      n_vec++;
      if (out_valid !== 1'b1 || out_exec !== tbl[i] || out_instr !== in_instr ||
          out_sets_flags !== 1'b0) begin
        $display("FAIL cond_table[%0d]: got v=%b exec=%b sf=%b instr=%h, required v=1 exec=%b sf=0 instr=%h",
                 i, out_valid, out_exec, out_sets_flags, out_instr, tbl[i], in_instr);
        n_err++;
      end
    end
    drive_idle();
    cycle();
  endtask

  task automatic test_hazard();
    logic [31:0] beq;
    drive_idle();
    status_in = 32'h0000_0000;
    in_valid = 1; in_sets_flags = 1; in_instr = {4'hE, 28'($urandom)};
    #1;
    cycle();
    beq = {4'h0, 28'($urandom)};
    in_sets_flags = 0; in_instr = beq;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
        $display("FAIL hazard_stall[%0d]: got in_ready=%b, required 0", k, in_ready);
        n_err++;
      end
      cycle();
    end
    flag_wb = 1;
    status_in = 32'h4000_0000;
    #1;
`ifdef CCS_FLAG_BYPASS_EN
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL hazard_wb_cycle: got in_ready=%b, required 1", in_ready);
      n_err++;
    end
    cycle();
    flag_wb = 0; in_valid = 0;
`else
    n_vec++;
    if (in_ready !== 1'b0) begin
      $display("FAIL hazard_wb_cycle: got in_ready=%b, required 0", in_ready);
      n_err++;
    end
    cycle();
    flag_wb = 0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL hazard_after_wb: got in_ready=%b, required 1", in_ready);
      n_err++;
    end
    cycle();
    in_valid = 0;
`endif
    n_vec++;
    if (out_valid !== 1'b1 || out_exec !== 1'b1 || out_instr !== beq) begin
      $display("FAIL hazard_beq_out: got v=%b exec=%b instr=%h, required v=1 exec=1 instr=%h",
               out_valid, out_exec, out_instr, beq);
      n_err++;
    end
    cycle();
  endtask

  task automatic test_backpressure();
    logic [31:0] i1, i2;
    drive_idle();
    i1 = {4'hE, 28'($urandom)};
    i2 = {4'hE, 28'($urandom)};
    out_ready = 0; in_valid = 1; in_instr = i1;
    #1;
    cycle();
    in_instr = i2;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== i1) begin
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b instr=%h, required rdy=0 v=1 instr=%h",
                 k, in_ready, out_valid, out_instr, i1);
        n_err++;
      end
      cycle();
    end
    out_ready = 1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL bp_release: got in_ready=%b, required 1", in_ready);
      n_err++;
    end
    cycle();
    n_vec++;
    if (out_valid !== 1'b1 || out_instr !== i2) begin
      $display("FAIL bp_second: got v=%b instr=%h, required v=1 instr=%h", out_valid, out_instr, i2);
      n_err++;
    end
    drive_idle();
    cycle();
  endtask

  task automatic test_saturation();
    drive_idle();
    status_in = $urandom;
    in_valid = 1; in_sets_flags = 1;
    for (int k = 0; k < PendMax; k++) begin
      in_instr = {4'hE, 28'($urandom)};
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        $display("FAIL sat_accept[%0d]: got in_ready=%b, required 1", k, in_ready);
        n_err++;
      end
      cycle();
    end
    in_instr = {4'hE, 28'($urandom)};
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
        $display("FAIL sat_stall[%0d]: got in_ready=%b, required 0", k, in_ready);
        n_err++;
      end
      cycle();
    end
    flag_wb = 1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL sat_release: got in_ready=%b, required 1", in_ready);
      n_err++;
    end
    cycle();
    flag_wb = 0; in_valid = 0; in_sets_flags = 0;
    cycle();
    flag_wb = 1;
    repeat (PendMax) cycle();
    n_vec++;
    if (err_underflow !== 1'b0) begin
      $display("FAIL sat_no_err: got err_underflow=%b, required 0", err_underflow);
      n_err++;
    end
    cycle();
    flag_wb = 0;
    n_vec++;
    if (err_underflow !== 1'b1) begin
      $display("FAIL sat_underflow: got err_underflow=%b, required 1", err_underflow);
      n_err++;
    end
    in_valid = 1; in_instr = {4'h0, 28'($urandom)};
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL sat_pend_zero: got in_ready=%b, required 1", in_ready);
      n_err++;
    end
    cycle();
    drive_idle();
    cycle();
  endtask

  task automatic test_flush();
    drive_idle();
    out_ready = 0; in_valid = 1; in_sets_flags = 1; in_instr = {4'hE, 28'($urandom)};
    #1;
    cycle();
    flush = 1; out_ready = 1; in_sets_flags = 0; in_instr = {4'h1, 28'($urandom)};
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      $display("FAIL flush_ready: got in_ready=%b, required 0", in_ready);
      n_err++;
    end
    cycle();
    flush = 0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL flush_clear: got out_valid=%b, required 0", out_valid);
      n_err++;
    end
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL flush_no_stall: got in_ready=%b, required 1", in_ready);
      n_err++;
    end
    cycle();
    n_vec++;
    if (out_valid !== 1'b1 || out_instr !== in_instr) begin
      $display("FAIL flush_next: got v=%b instr=%h, required v=1 instr=%h",
               out_valid, out_instr, in_instr);
      n_err++;
    end
    drive_idle();
    cycle();
  endtask

  task automatic test_reset();
    drive_idle();
    out_ready = 0; in_valid = 1; in_sets_flags = 1; in_instr = {4'hE, 28'($urandom)};
    #1;
    cycle();
    #2;
    rst_n = 0;
    #1;
    n_vec++;
    if ({out_valid, out_exec, out_sets_flags, err_underflow, out_instr} !== '0) begin
      $display("FAIL reset_async: got v=%b e=%b sf=%b err=%b instr=%h, required all 0",
               out_valid, out_exec, out_sets_flags, err_underflow, out_instr);
      n_err++;
    end
    model_reset();
    drive_idle();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    in_valid = 1; in_instr = {4'h0, 28'($urandom)};
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_forgets_pend: got in_ready=%b, required 1", in_ready);
      n_err++;
    end
    cycle();
    drive_idle();
    cycle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      in_valid      = ($urandom_range(9) < 7);
      in_instr      = $urandom;
      in_sets_flags = ($urandom_range(9) < 4);
      status_in     = $urandom;
      out_ready     = ($urandom_range(9) < 7);
      flush         = ($urandom_range(19) == 0);
      flag_wb       = (m_pend > 0) && ($urandom_range(2) == 0);
      #1;
      n_vec++;
      if (in_ready !== exp_ready()) begin
        $display("FAIL rand_ready[%0d]: got %b, required %b", k, in_ready, exp_ready());
        n_err++;
      end
      cycle();
      n_vec++;
      if (out_valid !== m_ov || err_underflow !== m_err) begin
        $display("FAIL rand_state[%0d]: got v=%b err=%b, required v=%b err=%b",
                 k, out_valid, err_underflow, m_ov, m_err);
        n_err++;
      end
      if (m_ov) begin
        n_vec++;
        if (out_instr !== m_instr || out_exec !== m_exec || out_sets_flags !== m_sf) begin
          $display("FAIL rand_data[%0d]: got instr=%h exec=%b sf=%b, required instr=%h exec=%b sf=%b",
                   k, out_instr, out_exec, out_sets_flags, m_instr, m_exec, m_sf);
          n_err++;
        end
      end
    end
    drive_idle();
    cycle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_power_on();
    test_cond_table();
    test_hazard();
    test_backpressure();
    test_saturation();
    test_flush();
    test_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
